spring_scheduler: RTL and testbench
===================================

SPRING_SCHEDULER -- requirements
Module: spring_scheduler

Interface
REQ-001 SHALL have parameter NUM_SPRINGS, default 8, number of entries in the spring table.
REQ-002 SHALL have parameter NUM_NODES, default 8, number of point masses.
REQ-003 SHALL have parameters POSITION_SIZE 8, VELOCITY_SIZE 7, FORCE_SIZE 5, matching the spring unit widths.
REQ-004 SHALL have parameter ACC_SIZE, default 10, width of the signed per-node force accumulators.
REQ-005 SHALL have parameter TIMEOUT, default 255, spring-unit watchdog limit in cycles.
REQ-006 Port clk_in, input, 1, system clock; all logic is rising-edge.
REQ-007 Port rst_n_in, input, 1, asynchronous active-low reset.
REQ-008 Port start_in, input, 1, one-cycle pulse that begins a force pass.
REQ-009 Port busy_out, output, 1, high while a pass is in progress.
REQ-010 Port done_out, output, 1, one-cycle pulse when a pass completes.
REQ-011 Port spr_idx_out, output, clog2(NUM_SPRINGS), spring-table read address.
REQ-012 Port node_a_in / node_b_in, input, clog2(NUM_NODES) each, spring endpoints, valid 1 cycle after the address.
REQ-013 Port node_idx_out, output, clog2(NUM_NODES), node-state read address.
REQ-014 Port pos_x_in / pos_y_in (POSITION_SIZE) and vel_x_in / vel_y_in (VELOCITY_SIZE), input, signed node state, valid 1 cycle after the address.
REQ-015 Port spr_valid_out, output, 1, input_valid pulse to the spring unit.
REQ-016 Ports spr_v1_out / spr_v2_out (2 x POSITION_SIZE) and spr_vel1_x/y_out / spr_vel2_x/y_out (VELOCITY_SIZE), output, signed, registered spring-unit operands.
REQ-017 Ports spr_done_in (1) and spr_fx_in / spr_fy_in (FORCE_SIZE, signed), input, spring-unit result_valid and force.
REQ-018 Ports acc_rd_idx_in (input, clog2(NUM_NODES)) and acc_fx_out / acc_fy_out (output, ACC_SIZE, signed), combinational read of the accumulators for the integrator.
REQ-019 Port err_out, output, 1, sticky overflow/timeout flag, cleared by start_in.

Function
REQ-020 FSM states SHALL be IDLE, CLEAR, FETCH_SPR, FETCH_A, FETCH_B, ISSUE, WAIT, ACC_A, ACC_B, DONE.
REQ-021 IDLE->CLEAR on start_in; start_in SHALL be ignored when busy_out=1.
REQ-022 CLEAR SHALL zero one accumulator pair per cycle, NUM_NODES cycles, then set spring index 0 and go to FETCH_SPR.
REQ-023 FETCH_SPR SHALL drive spr_idx_out and latch the endpoints one cycle later. FETCH_A/FETCH_B SHALL each read node state with 1-cycle latency into the v1/vel1 and v2/vel2 operand registers.
REQ-024 ISSUE SHALL assert spr_valid_out for exactly one cycle with stable operands, then enter WAIT.
REQ-025 WAIT SHALL hold the operands until spr_done_in and latch spr_fx_in / spr_fy_in on that cycle.
REQ-026 ACC_A SHALL add the force to node A; ACC_B SHALL subtract it from node B, sign-extended to ACC_SIZE.
REQ-027 Accumulation SHALL saturate at +/-(2^(ACC_SIZE-1)-1 / 2^(ACC_SIZE-1)) and set err_out on saturation.
REQ-028 If node_a == node_b, the spring SHALL be skipped (no issue) and the index advanced.
REQ-029 After ACC_B on index NUM_SPRINGS-1 the FSM SHALL go to DONE (done_out=1 for one cycle), then IDLE; otherwise it SHALL increment the index and return to FETCH_SPR.
REQ-030 busy_out SHALL be high in every state except IDLE.
REQ-031 Accumulator reads while busy_out=1 SHALL return in-progress values; only values read after done_out are defined.

Reset
REQ-032 Asserting rst_n_in low SHALL immediately force IDLE, busy_out=0, done_out=0, spr_valid_out=0, err_out=0, and all operand registers, index and accumulators to 0, including mid-pass.

Configuration
REQ-033 With SPRING_TIMEOUT_EN defined, a WAIT-state counter SHALL abort the spring after TIMEOUT cycles without spr_done_in, set err_out, skip accumulation and advance the index.
REQ-034 Without SPRING_TIMEOUT_EN, WAIT SHALL wait indefinitely and contain no counter logic.

Verification
REQ-035 One spring, nodes 0(2,2) and 1(2,4), model returns fy=+3 -> acc_fy[0]=+3, acc_fy[1]=-3, all x=0, done_out pulsed once.
REQ-036 Two springs sharing node 1, each returning fx=+5 -> acc_fx[1]=-10 on a 1-0 / 1-2 arrangement, with correct sum on shared nodes.
REQ-037 ACC_SIZE=5, eight springs into node 0 each fx=+15 -> acc_fx[0]=+15 saturated, err_out=1.
REQ-038 rst_n_in low during WAIT -> outputs 0 in the same cycle; next start_in completes a clean pass.
REQ-039 SPRING_TIMEOUT_EN with spring model mute, TIMEOUT=4 -> spring skipped after 4 cycles, err_out=1, done_out still pulses.
REQ-040 start_in while busy, and a spring with node_a=node_b=3 -> start_in ignored, no spr_valid_out for that spring.

Source files
------------

// File: rtl/spring_scheduler.sv
// Force-pass sequencer: walks the spring table, feeds each spring to an external
// spring unit and accumulates the returned forces per node. Optional watchdog: SPRING_TIMEOUT_EN.
module spring_scheduler #(
    parameter int NUM_SPRINGS   = 8,
    parameter int NUM_NODES     = 8,
    parameter int POSITION_SIZE = 8,
    parameter int VELOCITY_SIZE = 7,
    parameter int FORCE_SIZE    = 5,
    parameter int ACC_SIZE      = 10,
    parameter int TIMEOUT       = 255,
    localparam int SW = (NUM_SPRINGS > 1) ? $clog2(NUM_SPRINGS) : 1,
    localparam int NW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              start_in,
    output logic                              busy_out,
    output logic                              done_out,
    output logic [SW-1:0]                     spr_idx_out,
    input  logic [NW-1:0]                     node_a_in,
    input  logic [NW-1:0]                     node_b_in,
    output logic [NW-1:0]                     node_idx_out,
    input  logic signed [POSITION_SIZE-1:0]   pos_x_in,
    input  logic signed [POSITION_SIZE-1:0]   pos_y_in,
    input  logic signed [VELOCITY_SIZE-1:0]   vel_x_in,
    input  logic signed [VELOCITY_SIZE-1:0]   vel_y_in,
    output logic                              spr_valid_out,
    output logic signed [2*POSITION_SIZE-1:0] spr_v1_out,
    output logic signed [2*POSITION_SIZE-1:0] spr_v2_out,
    output logic signed [VELOCITY_SIZE-1:0]   spr_vel1_x_out,
    output logic signed [VELOCITY_SIZE-1:0]   spr_vel1_y_out,
    output logic signed [VELOCITY_SIZE-1:0]   spr_vel2_x_out,
    output logic signed [VELOCITY_SIZE-1:0]   spr_vel2_y_out,
    input  logic                              spr_done_in,
    input  logic signed [FORCE_SIZE-1:0]      spr_fx_in,
    input  logic signed [FORCE_SIZE-1:0]      spr_fy_in,
    input  logic [NW-1:0]                     acc_rd_idx_in,
    output logic signed [ACC_SIZE-1:0]        acc_fx_out,
    output logic signed [ACC_SIZE-1:0]        acc_fy_out,
    output logic                              err_out
);

    // state     | meaning
    // IDLE      | waiting for start_in
    // CLEAR     | zero one accumulator pair per cycle
    // FETCH_SPR | phase 0: address spring table, phase 1: latch endpoints
    // FETCH_A   | phase 0: address node A, phase 1: latch v1/vel1
    // FETCH_B   | phase 0: address node B, phase 1: latch v2/vel2
    // ISSUE     | spr_valid_out for one cycle
    // WAIT      | hold operands until spr_done_in (or watchdog abort)
    // ACC_A     | add force to node A
    // ACC_B     | subtract force from node B, then advance
    // DONE      | done_out pulse
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] CLEAR     = 4'd1;
    localparam logic [3:0] FETCH_SPR = 4'd2;
    localparam logic [3:0] FETCH_A   = 4'd3;
    localparam logic [3:0] FETCH_B   = 4'd4;
    localparam logic [3:0] ISSUE     = 4'd5;
    localparam logic [3:0] WAIT      = 4'd6;
    localparam logic [3:0] ACC_A     = 4'd7;
    localparam logic [3:0] ACC_B     = 4'd8;
    localparam logic [3:0] DONE      = 4'd9;

    // Two guard bits: accumulator minus the most negative force cannot wrap.
    localparam int SUM_W = ((ACC_SIZE > FORCE_SIZE) ? ACC_SIZE : FORCE_SIZE) + 2;
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (ACC_SIZE - 1)) - 1);
    localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(-(2 ** (ACC_SIZE - 1)));
    localparam logic [SW-1:0] LAST_SPR  = SW'(NUM_SPRINGS - 1);
    localparam logic [NW-1:0] LAST_NODE = NW'(NUM_NODES - 1);

    logic [3:0]                       state;
    logic                             phase;
    logic [SW-1:0]                    spr_idx;
    logic [NW-1:0]                    clr_idx;
    logic [NW-1:0]                    node_a;
    logic [NW-1:0]                    node_b;
    logic signed [POSITION_SIZE-1:0]  v1_x, v1_y, v2_x, v2_y;
    logic signed [VELOCITY_SIZE-1:0]  vel1_x, vel1_y, vel2_x, vel2_y;
    logic signed [FORCE_SIZE-1:0]     force_x, force_y;
    logic                             err;
    logic signed [ACC_SIZE-1:0]       acc_fx [NUM_NODES];
    logic signed [ACC_SIZE-1:0]       acc_fy [NUM_NODES];

    logic                             last_spr;
    logic                             wait_abort;
    logic [NW-1:0]                    acc_node;
    logic signed [SUM_W-1:0]          cur_x, cur_y, add_x, add_y, sum_x, sum_y;
    logic signed [ACC_SIZE-1:0]       sat_x, sat_y;
    logic                             ovf_x, ovf_y;

    assign last_spr = (spr_idx == LAST_SPR);

`ifdef SPRING_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= TW'(TIMEOUT - 1);
        end else if ((state == WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - TW'(1);
        end
    end

    assign wait_abort = (state == WAIT) && (wait_cnt == '0);
`else
    // No watchdog in this build: WAIT only leaves on spr_done_in.
    assign wait_abort = (TIMEOUT < 0);
`endif

    always_comb begin
        acc_node = (state == ACC_B) ? node_b : node_a;
        cur_x = {{(SUM_W - ACC_SIZE){acc_fx[acc_node][ACC_SIZE-1]}}, acc_fx[acc_node]};
        cur_y = {{(SUM_W - ACC_SIZE){acc_fy[acc_node][ACC_SIZE-1]}}, acc_fy[acc_node]};
        add_x = {{(SUM_W - FORCE_SIZE){force_x[FORCE_SIZE-1]}}, force_x};
        add_y = {{(SUM_W - FORCE_SIZE){force_y[FORCE_SIZE-1]}}, force_y};
        if (state == ACC_B) begin
            add_x = -add_x;
            add_y = -add_y;
        end
        sum_x = cur_x + add_x;
        sum_y = cur_y + add_y;
        ovf_x = (sum_x > ACC_MAX) || (sum_x < ACC_MIN);
        ovf_y = (sum_y > ACC_MAX) || (sum_y < ACC_MIN);
        sat_x = (sum_x > ACC_MAX) ? ACC_MAX[ACC_SIZE-1:0] :
                (sum_x < ACC_MIN) ? ACC_MIN[ACC_SIZE-1:0] : sum_x[ACC_SIZE-1:0];
        sat_y = (sum_y > ACC_MAX) ? ACC_MAX[ACC_SIZE-1:0] :
                (sum_y < ACC_MIN) ? ACC_MIN[ACC_SIZE-1:0] : sum_y[ACC_SIZE-1:0];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= IDLE;
            phase   <= 1'b0;
            spr_idx <= '0;
            clr_idx <= '0;
            node_a  <= '0;
            node_b  <= '0;
            v1_x    <= '0;
            v1_y    <= '0;
            v2_x    <= '0;
            v2_y    <= '0;
            vel1_x  <= '0;
            vel1_y  <= '0;
            vel2_x  <= '0;
            vel2_y  <= '0;
            force_x <= '0;
            force_y <= '0;
            err     <= 1'b0;
            for (int i = 0; i < NUM_NODES; i++) begin
                acc_fx[i] <= '0;
                acc_fy[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                        err     <= 1'b0;
                    end
                end
                CLEAR: begin
                    acc_fx[clr_idx] <= '0;
                    acc_fy[clr_idx] <= '0;
                    if (clr_idx == LAST_NODE) begin
                        spr_idx <= '0;
                        phase   <= 1'b0;
                        state   <= FETCH_SPR;
                    end else begin
                        clr_idx <= clr_idx + NW'(1);
                    end
                end
                FETCH_SPR: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase  <= 1'b0;
                        node_a <= node_a_in;
                        node_b <= node_b_in;
                        // A spring tied to a single node carries no force.
                        if (node_a_in == node_b_in) begin
                            if (last_spr) begin
                                state <= DONE;
                            end else begin
                                spr_idx <= spr_idx + SW'(1);
                                state   <= FETCH_SPR;
                            end
                        end else begin
                            state <= FETCH_A;
                        end
                    end
                end
                FETCH_A: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase  <= 1'b0;
                        v1_x   <= pos_x_in;
                        v1_y   <= pos_y_in;
                        vel1_x <= vel_x_in;
                        vel1_y <= vel_y_in;
                        state  <= FETCH_B;
                    end
                end
                FETCH_B: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase  <= 1'b0;
                        v2_x   <= pos_x_in;
                        v2_y   <= pos_y_in;
                        vel2_x <= vel_x_in;
                        vel2_y <= vel_y_in;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (spr_done_in) begin
                        force_x <= spr_fx_in;
                        force_y <= spr_fy_in;
                        state   <= ACC_A;
                    end else if (wait_abort) begin
                        err <= 1'b1;
                        if (last_spr) begin
                            state <= DONE;
                        end else begin
                            spr_idx <= spr_idx + SW'(1);
                            state   <= FETCH_SPR;
                        end
                    end
                end
                ACC_A: begin
                    acc_fx[node_a] <= sat_x;
                    acc_fy[node_a] <= sat_y;
                    if (ovf_x || ovf_y) begin
                        err <= 1'b1;
                    end
                    state <= ACC_B;
                end
                ACC_B: begin
                    acc_fx[node_b] <= sat_x;
                    acc_fy[node_b] <= sat_y;
                    if (ovf_x || ovf_y) begin
                        err <= 1'b1;
                    end
                    if (last_spr) begin
                        state <= DONE;
                    end else begin
                        spr_idx <= spr_idx + SW'(1);
                        state   <= FETCH_SPR;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy_out       = (state != IDLE);
    assign done_out       = (state == DONE);
    assign spr_valid_out  = (state == ISSUE);
    assign spr_idx_out    = spr_idx;
    assign node_idx_out   = (state == FETCH_B) ? node_b : node_a;
    assign spr_v1_out     = {v1_x, v1_y};
    assign spr_v2_out     = {v2_x, v2_y};
    assign spr_vel1_x_out = vel1_x;
    assign spr_vel1_y_out = vel1_y;
    assign spr_vel2_x_out = vel2_x;
    assign spr_vel2_y_out = vel2_y;
    assign acc_fx_out     = acc_fx[acc_rd_idx_in];
    assign acc_fy_out     = acc_fy[acc_rd_idx_in];
    assign err_out        = err;

endmodule

// File: tb/tb_spring_scheduler.sv
// Randomised bench for spring_scheduler: table-driven spring unit model and a
// plain-arithmetic force accumulation reference, plus a few literal scenarios.
module tb_spring_scheduler;
    localparam int NS = 8;
    localparam int NN = 8;
    localparam int PS = 8;
    localparam int VS = 7;
    localparam int FS = 5;
    localparam int AS = 5;
    localparam int TO = 4;
    localparam int AMAX = (2 ** (AS - 1)) - 1;
    localparam int AMIN = -(2 ** (AS - 1));

    logic                    clk_in = 1'b0;
    logic                    rst_n_in;
    logic                    start_in;
    logic                    busy_out, done_out, spr_valid_out, err_out;
    logic [2:0]              spr_idx_out, node_idx_out;
    logic [2:0]              node_a_in, node_b_in;
    logic signed [PS-1:0]    pos_x_in, pos_y_in;
    logic signed [VS-1:0]    vel_x_in, vel_y_in;
    logic signed [2*PS-1:0]  spr_v1_out, spr_v2_out;
    logic signed [VS-1:0]    spr_vel1_x_out, spr_vel1_y_out, spr_vel2_x_out, spr_vel2_y_out;
    logic                    spr_done_in;
    logic signed [FS-1:0]    spr_fx_in, spr_fy_in;
    logic [2:0]              acc_rd_idx_in;
    logic signed [AS-1:0]    acc_fx_out, acc_fy_out;

    spring_scheduler #(
        .NUM_SPRINGS(NS), .NUM_NODES(NN), .POSITION_SIZE(PS), .VELOCITY_SIZE(VS),
        .FORCE_SIZE(FS), .ACC_SIZE(AS), .TIMEOUT(TO)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
        .busy_out(busy_out), .done_out(done_out), .spr_idx_out(spr_idx_out),
        .node_a_in(node_a_in), .node_b_in(node_b_in), .node_idx_out(node_idx_out),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .vel_x_in(vel_x_in), .vel_y_in(vel_y_in),
        .spr_valid_out(spr_valid_out), .spr_v1_out(spr_v1_out), .spr_v2_out(spr_v2_out),
        .spr_vel1_x_out(spr_vel1_x_out), .spr_vel1_y_out(spr_vel1_y_out),
        .spr_vel2_x_out(spr_vel2_x_out), .spr_vel2_y_out(spr_vel2_y_out),
        .spr_done_in(spr_done_in), .spr_fx_in(spr_fx_in), .spr_fy_in(spr_fy_in),
        .acc_rd_idx_in(acc_rd_idx_in), .acc_fx_out(acc_fx_out), .acc_fy_out(acc_fy_out),
        .err_out(err_out)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;

    int spr_a [NS], spr_b [NS], fxs [NS], fys [NS];
    int px [NN], py [NN], vx [NN], vy [NN];
    int m_fx [NN], m_fy [NN];
    bit m_err;
    int exp_q [$];
    bit mute = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampa(input int v);
        if (v > AMAX) return AMAX;
        if (v < AMIN) return AMIN;
        return v;
    endfunction

    // Reference: sum each non-degenerate spring's force into A, out of B, with clamping.
    task automatic build_model(input bit mute_i);
        int t;
        m_err = 1'b0;
        exp_q.delete();
        for (int n = 0; n < NN; n++) begin
            m_fx[n] = 0;
            m_fy[n] = 0;
        end
        for (int s = 0; s < NS; s++) begin
            if (spr_a[s] != spr_b[s]) begin
                exp_q.push_back(s);
                if (mute_i) begin
                    m_err = 1'b1;
                end else begin
                    t = m_fx[spr_a[s]] + fxs[s]; if (clampa(t) != t) m_err = 1'b1; m_fx[spr_a[s]] = clampa(t);
                    t = m_fy[spr_a[s]] + fys[s]; if (clampa(t) != t) m_err = 1'b1; m_fy[spr_a[s]] = clampa(t);
                    t = m_fx[spr_b[s]] - fxs[s]; if (clampa(t) != t) m_err = 1'b1; m_fx[spr_b[s]] = clampa(t);
                    t = m_fy[spr_b[s]] - fys[s]; if (clampa(t) != t) m_err = 1'b1; m_fy[spr_b[s]] = clampa(t);
                end
            end
        end
    endtask

    // Spring table and node state memories: one cycle read latency.
    always @(posedge clk_in) begin
        node_a_in <= 3'(spr_a[spr_idx_out]);
        node_b_in <= 3'(spr_b[spr_idx_out]);
        pos_x_in  <= PS'(px[node_idx_out]);
        pos_y_in  <= PS'(py[node_idx_out]);
        vel_x_in  <= VS'(vx[node_idx_out]);
        vel_y_in  <= VS'(vy[node_idx_out]);
    end

    // Spring unit model: checks operands against the expected spring, answers after 1..3 cycles.
    initial begin
        spr_done_in = 1'b0;
        spr_fx_in   = '0;
        spr_fy_in   = '0;
    end

    always begin : spring_unit
        int s, a, b, d, n;
        logic [2:0] idx0;
        @(negedge clk_in);
        if (spr_valid_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", 1, 0);
            end else begin
                s = exp_q.pop_front();
                a = spr_a[s];
                b = spr_b[s];
                chk("v1", longint'($unsigned(spr_v1_out)), longint'({PS'(px[a]), PS'(py[a])}));
                chk("v2", longint'($unsigned(spr_v2_out)), longint'({PS'(px[b]), PS'(py[b])}));
                chk("vel1_x", spr_vel1_x_out, vx[a]);
                chk("vel1_y", spr_vel1_y_out, vy[a]);
                chk("vel2_x", spr_vel2_x_out, vx[b]);
                chk("vel2_y", spr_vel2_y_out, vy[b]);
                if (mute) begin
                    idx0 = spr_idx_out;
                    n = 0;
                    while (n < 20 && spr_idx_out == idx0 && !done_out) begin
                        @(negedge clk_in);
                        n++;
                    end
                    chk("timeout_cycles", n, TO + 1);
                end else begin
                    d = $urandom_range(1, 3);
                    repeat (d) @(negedge clk_in);
                    chk("operands_held", longint'($unsigned(spr_v1_out)), longint'({PS'(px[a]), PS'(py[a])}));
                    spr_done_in = 1'b1;
                    spr_fx_in   = FS'(fxs[s]);
                    spr_fy_in   = FS'(fys[s]);
                    @(negedge clk_in);
                    spr_done_in = 1'b0;
                end
            end
        end
    end

    // Per-cycle protocol checks on meaningful cycles.
    always begin : protocol
        bit prev_valid;
        @(negedge clk_in);
        if (spr_valid_out) begin
            chk("valid_single_cycle", prev_valid, 0);
            chk("busy_at_issue", busy_out, 1);
        end
        if (done_out) chk("busy_at_done", busy_out, 1);
        prev_valid = spr_valid_out;
    end

    task automatic run_pass(input bit mute_i, input bit poke_start);
        int cyc, dones;
        build_model(mute_i);
        mute = mute_i;
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        cyc = 0;
        dones = 0;
        while (dones == 0 && cyc < 3000) begin
            @(negedge clk_in);
            cyc++;
            start_in = poke_start && (cyc == 15);
            if (done_out) dones++;
        end
        start_in = 1'b0;
        if (dones == 0) begin
            chk("done_timeout", 0, 1);
            return;
        end
        repeat (5) begin
            @(negedge clk_in);
            if (done_out) dones++;
        end
        chk("done_pulses", dones, 1);
        chk("busy_after_done", busy_out, 0);
        chk("issues_left", exp_q.size(), 0);
        chk("err", err_out, m_err);
        for (int n = 0; n < NN; n++) begin
            acc_rd_idx_in = 3'(n);
            #1;
            chk("acc_fx", acc_fx_out, m_fx[n]);
            chk("acc_fy", acc_fy_out, m_fy[n]);
        end
        mute = 1'b0;
    endtask

    task automatic read_acc(input int n);
        acc_rd_idx_in = 3'(n);
        #1;
    endtask

    task automatic zero_tables();
        for (int s = 0; s < NS; s++) begin
            spr_a[s] = 3; spr_b[s] = 3; fxs[s] = 0; fys[s] = 0;
        end
        for (int n = 0; n < NN; n++) begin
            px[n] = 0; py[n] = 0; vx[n] = 0; vy[n] = 0;
        end
    endtask

    task automatic random_tables();
        for (int s = 0; s < NS; s++) begin
            spr_a[s] = $urandom_range(0, NN - 1);
            spr_b[s] = $urandom_range(0, NN - 1);
            fxs[s]   = $urandom_range(0, 31) - 16;
            fys[s]   = $urandom_range(0, 31) - 16;
        end
        for (int n = 0; n < NN; n++) begin
            px[n] = $urandom_range(0, 255) - 128;
            py[n] = $urandom_range(0, 255) - 128;
            vx[n] = $urandom_range(0, 127) - 64;
            vy[n] = $urandom_range(0, 127) - 64;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin : main
        int cyc;
        rst_n_in = 1'b0;
        start_in = 1'b0;
        acc_rd_idx_in = '0;
        zero_tables();
        repeat (3) @(negedge clk_in);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_valid", spr_valid_out, 0);
        chk("rst_err", err_out, 0);
        chk("rst_idx", spr_idx_out, 0);
        chk("rst_acc", acc_fx_out, 0);
        rst_n_in = 1'b1;

        // One spring between nodes 0 (2,2) and 1 (2,4); the rest are self-loops on node 3.
        zero_tables();
        spr_a[0] = 0; spr_b[0] = 1; fys[0] = 3;
        px[0] = 2; py[0] = 2; px[1] = 2; py[1] = 4;
        run_pass(1'b0, 1'b1);
        read_acc(0); chk("lit_fy0", acc_fy_out, 3);  chk("lit_fx0", acc_fx_out, 0);
        read_acc(1); chk("lit_fy1", acc_fy_out, -3); chk("lit_fx1", acc_fx_out, 0);

        // Two springs both pulling node 1 as their B end.
        zero_tables();
        spr_a[0] = 0; spr_b[0] = 1; fxs[0] = 5;
        spr_a[1] = 2; spr_b[1] = 1; fxs[1] = 5;
        run_pass(1'b0, 1'b0);
        read_acc(1); chk("lit_shared_fx1", acc_fx_out, -10);
        read_acc(0); chk("lit_shared_fx0", acc_fx_out, 5);

        // Eight springs into node 0 at +15 each: saturation.
        zero_tables();
        for (int s = 0; s < NS; s++) begin
            spr_a[s] = 0; spr_b[s] = (s % 7) + 1; fxs[s] = 15;
        end
        run_pass(1'b0, 1'b0);
        read_acc(0); chk("lit_sat_fx0", acc_fx_out, 15);
        chk("lit_sat_err", err_out, 1);

        // Reset during WAIT, then a clean pass.
        random_tables();
        spr_a[0] = 1; spr_b[0] = 2;
        build_model(1'b0);
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        cyc = 0;
        while (!spr_valid_out && cyc < 200) begin
            @(negedge clk_in);
            cyc++;
        end
        chk("reached_issue", spr_valid_out, 1);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        chk("mid_rst_busy", busy_out, 0);
        chk("mid_rst_done", done_out, 0);
        chk("mid_rst_valid", spr_valid_out, 0);
        chk("mid_rst_err", err_out, 0);
        chk("mid_rst_idx", spr_idx_out, 0);
        chk("mid_rst_v1", longint'($unsigned(spr_v1_out)), 0);
        chk("mid_rst_vel2x", spr_vel2_x_out, 0);
        read_acc(1); chk("mid_rst_acc", acc_fx_out, 0);
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (10) @(negedge clk_in);
        run_pass(1'b0, 1'b0);

`ifdef SPRING_TIMEOUT_EN
        zero_tables();
        spr_a[0] = 4; spr_b[0] = 5; fxs[0] = 7;
        run_pass(1'b1, 1'b0);
        chk("lit_timeout_err", err_out, 1);
`endif

        for (int p = 0; p < 25; p++) begin
            random_tables();
            run_pass(1'b0, ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
